// File: rtl/mac_pkg.sv
// Shared MAC-array definitions: feeder state encodings and the operand
// handshake bit ordering that both the MAC and its feeders agree on.
`default_nettype none

package mac_pkg;

  localparam logic [2:0] FEED_IDLE   = 3'd0;
  localparam logic [2:0] FEED_SKEW   = 3'd1;
  localparam logic [2:0] FEED_SEND   = 3'd2;
  localparam logic [2:0] FEED_FINISH = 3'd3;
  localparam logic [2:0] FEED_DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = FEED_IDLE,
    ST_SKEW   = FEED_SKEW,
    ST_SEND   = FEED_SEND,
    ST_FINISH = FEED_FINISH,
    ST_DONE   = FEED_DONE
  } feed_state_t;

  // Bit positions of the operand handshake status vector {finished, waiting}.
  localparam int HS_W        = 2;
  localparam int HS_WAITING  = 0;
  localparam int HS_FINISHED = 1;

endpackage

`default_nettype wire

// File: rtl/mac_operand_buffer.sv
// Operand vector storage: one synchronous write port, one asynchronous
// read port, no reset.
`default_nettype none

module mac_operand_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/mac_operand_feeder.sv
// Transmit end of the MAC operand port: streams a buffered vector one element
// per handshake after a programmable skew, then sends the finish token.
`default_nettype none

module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int SKEW_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  input  logic [SKEW_W-1:0]     skew,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] D_out,
  output logic                  D_out_waiting,
  output logic                  D_out_finished,
  input  logic                  D_out_ready
);

  localparam int              LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  feed_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic [HS_W-1:0]       hs;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] rd_data;

  mac_operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en & ~busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      skew_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      skew_q  <= skew_d;
      len_q   <= len_d;
    end
  end

  // Moore outputs: nothing below depends on D_out_ready.
  always_comb begin
    hs              = '0;
    hs[HS_WAITING]  = (state_q == ST_SEND);
    hs[HS_FINISHED] = (state_q == ST_FINISH);
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign D_out_waiting  = hs[HS_WAITING];
  assign D_out_finished = hs[HS_FINISHED];
  assign D_out          = hs[HS_WAITING] ? rd_data : '0;
  assign xfer           = (|hs) & D_out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    skew_d  = skew_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d  = (len > LEN_MAX) ? LEN_MAX : len;
          skew_d = skew;
          idx_d  = '0;
          if (skew != '0)     state_d = ST_SKEW;
          else if (len != '0) state_d = ST_SEND;
          else                state_d = ST_FINISH;
        end
      end
      ST_SKEW: begin
        skew_d = skew_q - SKEW_W'(1);
        if (skew_q == SKEW_W'(1)) begin
          state_d = (len_q != '0) ? ST_SEND : ST_FINISH;
        end
      end
      ST_SEND: begin
        // The last index is held rather than incremented so len=DEPTH never wraps.
        if (xfer) begin
          if ({1'b0, idx_q} == len_q - LEN_W'(1)) state_d = ST_FINISH;
          else                                   idx_d   = idx_q + ADDR_W'(1);
        end
      end
      ST_FINISH: begin
        if (xfer) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
